// File: rtl/dla_pkg.sv
// Shared DLA definitions: vector geometry, DLA mode encodings and the
// ifmap/weight feeder FSM state type.
package dla_pkg;

  // Bytes per ifmap vector and per weight row.
  localparam int unsigned VEC_W  = 16;
  // Weight rows per weight block.
  localparam int unsigned W_ROWS = 16;

  // DLA operating modes, sampled when the feeder is started.
  typedef enum logic [1:0] {
    ModeConv = 2'd0,
    ModeFc   = 2'd1,
    ModeDw   = 2'd2,
    ModeIf3  = 2'd3   // ifmap vectors grouped in threes; marks every third
  } mode_e;

  // Feeder FSM states.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIfRd  = 3'd1,
    StIfCap = 3'd2,
    StWRd   = 3'd3,
    StWCap  = 3'd4,
    StWRdy  = 3'd5
  } state_e;

endpackage

// File: rtl/weight_row_loader.sv
// Weight row capture datapath.
// A read issued in cycle N returns data in cycle N+1; this block delays the
// issue strobe by one cycle and writes the returning word into the next row
// of the weight block, wrapping the row counter after the last row.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : abandons any in-flight capture and rewinds the row counter
//   issue_i       : a weight row read is being issued this cycle
//   rdata_i       : SRAM read data (valid the cycle after issue)
//   rows_o        : captured weight block, rows_o[r] = row r
module weight_row_loader #(
  parameter int unsigned VecW  = 16,
  parameter int unsigned WRows = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             issue_i,
  input  logic [8*VecW-1:0]                rdata_i,
  output logic [WRows-1:0][VecW-1:0][7:0]  rows_o
);

  localparam int unsigned RowW = (WRows > 1) ? $clog2(WRows) : 1;

  logic                             pend_q;
  logic [RowW-1:0]                  row_q;
  logic [WRows-1:0]                 row_we;
  logic [WRows-1:0][VecW-1:0][7:0]  rows_q;

  // One-hot write enable for the row whose data arrives this cycle.
  always_comb begin
    row_we = '0;
    if (pend_q) begin
      row_we[row_q] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= 1'b0;
      row_q  <= '0;
      rows_q <= '0;
    end else if (clear_i) begin
      // Rows already captured are left untouched; only the pending write dies.
      pend_q <= 1'b0;
      row_q  <= '0;
    end else begin
      pend_q <= issue_i;
      if (pend_q) begin
        row_q <= (row_q == RowW'(WRows - 1)) ? '0 : row_q + 1'b1;
      end
      for (int r = 0; r < WRows; r++) begin
        if (row_we[r]) begin
          rows_q[r] <= rdata_i;
        end
      end
    end
  end

  assign rows_o = rows_q;

endmodule

// File: rtl/ifmap_weight_feeder.sv
// Ifmap / weight feeder for the DLA.
// Serves level requests for ifmap vectors (one SRAM word each) and weight
// blocks (W_ROWS consecutive SRAM words each) out of a shared SRAM port.
// Weight requests win a tie. Each delivery is flagged by a one-cycle ready
// pulse; delivered data is held until the next delivery of the same kind.
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   start             : loads config, clears counters, aborts any transfer
//   mode              : DLA mode (mode 3 marks every third ifmap vector)
//   ifmap_base/len    : ifmap SRAM start address and vector count
//   weight_base/blocks: weight SRAM start address and block count
//   ifmap_valid       : ifmap request (level)
//   ifmap_ready       : ifmap_data valid pulse
//   ifmap_3_ready     : third-vector marker, pulses with ifmap_ready
//   ifmap_data        : delivered ifmap vector, byte k = SRAM bits [8k+7:8k]
//   weight_valid      : weight request (level)
//   weight_ready      : weight_data valid pulse
//   weight_data       : delivered weight block, weight_data[r] = row r
//   sram_ren/addr     : SRAM read port, data returns one cycle later
//   sram_rdata        : SRAM read data
//   feed_done         : both counts exhausted while idle
module ifmap_weight_feeder
  import dla_pkg::*;
#(
  parameter int unsigned VEC_W  = dla_pkg::VEC_W,
  parameter int unsigned W_ROWS = dla_pkg::W_ROWS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [1:0]                        mode,
  input  logic [15:0]                       ifmap_base,
  input  logic [15:0]                       ifmap_len,
  input  logic [15:0]                       weight_base,
  input  logic [7:0]                        weight_blocks,
  input  logic                              ifmap_valid,
  output logic                              ifmap_ready,
  output logic                              ifmap_3_ready,
  output logic [VEC_W-1:0][7:0]             ifmap_data,
  input  logic                              weight_valid,
  output logic                              weight_ready,
  output logic [W_ROWS-1:0][VEC_W-1:0][7:0] weight_data,
  output logic                              sram_ren,
  output logic [15:0]                       sram_addr,
  input  logic [8*VEC_W-1:0]                sram_rdata,
  output logic                              feed_done
);

  localparam int unsigned RowW = (W_ROWS > 1) ? $clog2(W_ROWS) : 1;

  state_e           state_q;
  mode_e            mode_q;
  logic [15:0]      ifmap_base_q, ifmap_len_q, weight_base_q;
  logic [7:0]       weight_blocks_q;
  logic [15:0]      if_cnt_q;
  logic [7:0]       w_cnt_q;
  logic [1:0]       mod3_q;     // if_cnt_q mod 3, avoids a divider
  logic [RowW-1:0]  rd_row_q;   // weight row currently being read
  logic             ifmap_ready_q, ifmap_3_ready_q, weight_ready_q;
  logic             sram_ren_q, feed_done_q;
  logic [15:0]      sram_addr_q;
  logic [VEC_W-1:0][7:0] ifmap_data_q;

  logic        if_left, w_left, if_req, w_req;
  logic [15:0] if_cnt_inc, if_addr, blk_addr;
  logic [7:0]  w_cnt_inc;

  assign if_left    = (if_cnt_q != ifmap_len_q);
  assign w_left     = (w_cnt_q != weight_blocks_q);
  assign if_cnt_inc = if_cnt_q + 16'd1;
  assign w_cnt_inc  = w_cnt_q + 8'd1;
  assign if_addr    = ifmap_base_q + if_cnt_q;
  assign blk_addr   = weight_base_q + 16'(32'(w_cnt_q) * W_ROWS);

  // A request is not re-accepted in the cycle its own ready pulses.
  assign w_req  = weight_valid && w_left && !weight_ready_q;
  assign if_req = ifmap_valid && if_left && !ifmap_ready_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      mode_q          <= ModeConv;
      ifmap_base_q    <= '0;
      ifmap_len_q     <= '0;
      weight_base_q   <= '0;
      weight_blocks_q <= '0;
      if_cnt_q        <= '0;
      w_cnt_q         <= '0;
      mod3_q          <= '0;
      rd_row_q        <= '0;
      ifmap_ready_q   <= 1'b0;
      ifmap_3_ready_q <= 1'b0;
      weight_ready_q  <= 1'b0;
      sram_ren_q      <= 1'b0;
      sram_addr_q     <= '0;
      feed_done_q     <= 1'b0;
      ifmap_data_q    <= '0;
    end else if (start) begin
      // Start wins over everything, including a request in the same cycle.
      state_q         <= StIdle;
      mode_q          <= mode_e'(mode);
      ifmap_base_q    <= ifmap_base;
      ifmap_len_q     <= ifmap_len;
      weight_base_q   <= weight_base;
      weight_blocks_q <= weight_blocks;
      if_cnt_q        <= '0;
      w_cnt_q         <= '0;
      mod3_q          <= '0;
      rd_row_q        <= '0;
      ifmap_ready_q   <= 1'b0;
      ifmap_3_ready_q <= 1'b0;
      weight_ready_q  <= 1'b0;
      sram_ren_q      <= 1'b0;
      feed_done_q     <= 1'b0;
    end else begin
      ifmap_ready_q   <= 1'b0;
      ifmap_3_ready_q <= 1'b0;
      weight_ready_q  <= 1'b0;
      sram_ren_q      <= 1'b0;
      unique case (state_q)
        StIdle: begin
          feed_done_q <= !if_left && !w_left;
          if (w_req) begin
            state_q     <= StWRd;
            sram_ren_q  <= 1'b1;
            sram_addr_q <= blk_addr;
            rd_row_q    <= '0;
          end else if (if_req) begin
            state_q     <= StIfRd;
            sram_ren_q  <= 1'b1;
            sram_addr_q <= if_addr;
          end
        end
        StIfRd: begin
          state_q <= StIfCap;
        end
        StIfCap: begin
          ifmap_data_q    <= sram_rdata;
          ifmap_ready_q   <= 1'b1;
          ifmap_3_ready_q <= (mode_q == ModeIf3) && (mod3_q == 2'd2);
          mod3_q          <= (mod3_q == 2'd2) ? 2'd0 : mod3_q + 2'd1;
          if_cnt_q        <= if_cnt_inc;
          feed_done_q     <= (if_cnt_inc == ifmap_len_q) && !w_left;
          state_q         <= StIdle;
        end
        StWRd: begin
          if (rd_row_q == RowW'(W_ROWS - 1)) begin
            state_q <= StWCap;
          end else begin
            sram_ren_q  <= 1'b1;
            sram_addr_q <= sram_addr_q + 16'd1;
            rd_row_q    <= rd_row_q + 1'b1;
          end
        end
        StWCap: begin
          // Final row lands in the loader this cycle.
          weight_ready_q <= 1'b1;
          state_q        <= StWRdy;
        end
        StWRdy: begin
          w_cnt_q     <= w_cnt_inc;
          feed_done_q <= !if_left && (w_cnt_inc == weight_blocks_q);
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  weight_row_loader #(
    .VecW  (VEC_W),
    .WRows (W_ROWS)
  ) u_weight_row_loader (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clear_i (start),
    .issue_i (state_q == StWRd),
    .rdata_i (sram_rdata),
    .rows_o  (weight_data)
  );

  assign ifmap_ready   = ifmap_ready_q;
  assign ifmap_3_ready = ifmap_3_ready_q;
  assign ifmap_data    = ifmap_data_q;
  assign weight_ready  = weight_ready_q;
  assign sram_ren      = sram_ren_q;
  assign sram_addr     = sram_addr_q;
  assign feed_done     = feed_done_q;

endmodule

// File: doc/ifmap_weight_feeder.md
IFMAP_WEIGHT_FEEDER -- requirements
Module: ifmap_weight_feeder

Interface
REQ-001 SHALL have parameter VEC_W, default 16, meaning bytes per ifmap vector and per weight row.
REQ-002 SHALL have parameter W_ROWS, default 16, meaning weight rows per weight block.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst input 1, reset when low.
REQ-004 SHALL have these ports:
- start  input  1  pulse; loads config and arms feeder
- mode  input  2  DLA mode, sampled at start
- ifmap_base  input  16  first ifmap SRAM word address
- ifmap_len  input  16  ifmap vectors to deliver; 0 means none
- weight_base  input  16  first weight SRAM word address
- weight_blocks  input  8  weight blocks to deliver; 0 means none
- ifmap_valid  input  1  level request for next ifmap vector
- ifmap_ready  output  1  one-cycle pulse; ifmap_data valid
- ifmap_3_ready  output  1  one-cycle pulse; third-vector marker in mode 3
- ifmap_data  output  8 x VEC_W  delivered ifmap vector
- weight_valid  input  1  level request for next weight block
- weight_ready  output  1  one-cycle pulse; weight_data valid
- weight_data  output  8 x W_ROWS x VEC_W  delivered weight block
- sram_ren  output  1  SRAM read enable
- sram_addr  output  16  SRAM word address
- sram_rdata  input  8*VEC_W  SRAM read data, valid one cycle after sram_ren
- feed_done  output  1  high when both counts are exhausted; cleared by start

Function
REQ-005 SHALL implement FSM states IDLE, IF_RD, IF_CAP, W_RD, W_CAP, W_RDY.
REQ-006 SHALL, in IDLE, move to W_RD if weight_valid is high and blocks remain; else to IF_RD if ifmap_valid is high and vectors remain; weight has priority on a tie.
REQ-007 SHALL, in IF_RD, drive sram_ren=1 with sram_addr=ifmap_base+if_cnt, then go to IF_CAP.
REQ-008 SHALL, in IF_CAP, register sram_rdata into ifmap_data, with byte k taken from rdata bits [8k+7:8k].
REQ-009 SHALL, in IF_CAP, pulse ifmap_ready on the next cycle, increment if_cnt, and return to IDLE; request-to-ready latency is 3 cycles.
REQ-010 SHALL pulse ifmap_3_ready with ifmap_ready only when mode==3 and the delivered index mod 3 == 2.
REQ-011 SHALL, in W_RD, issue W_ROWS back-to-back reads at weight_base+w_cnt*W_ROWS+r for r=0..W_ROWS-1.
REQ-012 SHALL capture each row one cycle later into weight_data[r]; W_CAP drains the final row.
REQ-013 SHALL, in W_RDY, pulse weight_ready for one cycle, increment w_cnt, and return to IDLE.
REQ-014 SHALL ignore ifmap_valid and weight_valid during the cycle in which the matching ready pulses, and while not in IDLE.
REQ-015 SHALL ignore requests once if_cnt==ifmap_len or w_cnt==weight_blocks; no ready is issued and no SRAM read occurs.
REQ-016 SHALL compute addresses modulo 2^16, wrapping silently.
REQ-017 SHALL hold ifmap_data and weight_data stable between deliveries.
REQ-018 SHALL assert feed_done in IDLE when both counts are exhausted.
REQ-019 SHALL, on start in any state, abort any transfer, clear counters and feed_done, load config, and enter IDLE; no ready pulse follows an aborted transfer.
REQ-020 SHALL, with start and a request in the same cycle, apply start first and evaluate the request next cycle.

Reset
REQ-021 SHALL, with rst low, asynchronously force state=IDLE, all counters=0, config registers=0, and ready pulses, sram_ren, sram_addr, feed_done, ifmap_data and weight_data to 0.

Structure
REQ-022 SHALL place the FSM state enum, VEC_W, W_ROWS and the mode encodings in shared package dla_pkg.
REQ-023 SHALL keep the row-capture datapath as sub-module weight_row_loader (row counter plus write-enable decode); everything else SHALL be flat.

Verification
REQ-024 ifmap_base=0x0100, ifmap_len=2, two requests -> sram_addr 0x0100 then 0x0101; each ifmap_ready 3 cycles after its request; data matches SRAM.
REQ-025 weight_base=0x0200, weight_blocks=1, weight_valid -> 16 consecutive reads 0x0200-0x020F; weight_ready 18 cycles after request; weight_data rows match.
REQ-026 weight_valid and ifmap_valid high together in IDLE -> weight block served first, ifmap served after weight_ready.
REQ-027 mode=3, ifmap_len=6, six requests -> ifmap_3_ready on deliveries 2 and 5 only.
REQ-028 ifmap_len=1, second request -> no sram_ren, no ready, feed_done=1 once weight_blocks=0.
REQ-029 rst low mid-W_RD (row 7) -> all outputs 0 immediately; after release, no weight_ready until a new request.
